traffic_light_monitor: RTL and testbench
========================================

// Module: traffic_light_monitor
// PURPOSE
//  Receive-side checker for the 3-bit RGB lamp bus driven by the traffic light controller.
//  Synchronises and glitch-filters RGB_in, then decodes the colour.
//  Measures each phase's dwell time in 10 ms ticks.
//  Checks GREEN->YELLOW->RED->GREEN ordering and per-phase duration; raises sticky fault flags.
//  Sits on the FPGA board next to the controller; drives status LEDs/ILA.
// PARAMETERS
//  TICK_DIV       1_000_000  clk cycles per tick (10 ms at 100 MHz); sim uses 10
//  STABLE_CYCLES  4          consecutive equal synced samples needed to accept a pattern
//  GREEN_TICKS    101        nominal green dwell, ticks
//  YELLOW_TICKS   51         nominal yellow dwell, ticks
//  RED_TICKS      101        nominal red dwell, ticks
//  TOL_TICKS      2          +/- tolerance on every dwell; NOMINAL+TOL must be < 1023
// PORTS
//  clk_100MHz     in   1   system clock
//  rst            in   1   asynchronous, active-high reset
//  RGB_in         in   3   lamp bus {R,G,B}, asynchronous to clk
//  clear_faults   in   1   1-cycle pulse, clears sticky fault flags
//  colour         out  2   accepted colour: 0 GREEN, 1 YELLOW, 2 RED, 3 NONE
//  colour_valid   out  1   colour is a legal tracked colour
//  phase_done     out  1   1-cycle pulse when a phase ends
//  phase_ticks    out  10  dwell of the phase just ended; saturates at 1023
//  fault_seq      out  1   sticky: illegal colour order
//  fault_time     out  1   sticky: dwell outside NOMINAL+/-TOL
//  fault_illegal  out  1   sticky: undefined RGB pattern accepted
//  cycle_count    out  16  count of legal RED->GREEN transitions; wraps
// BEHAVIOUR
//  Reset values:
//   - colour=3, colour_valid=0, phase_done=0, phase_ticks=0.
//   - All fault flags=0, cycle_count=0, FSM=IDLE.
//   - Synchroniser, filter, prescaler and tick counter cleared.
//  Input path: 2-FF sync, then stability filter.
//   - A pattern is accepted after it is seen STABLE_CYCLES consecutive cycles.
//   - Shorter pulses are ignored. Latency from RGB_in to colour is 2+STABLE_CYCLES cycles.
//  Decode:
//   - 010 -> GREEN, 110 -> YELLOW, 100 -> RED.
//   - Any other pattern (including B=1) is ILLEGAL.
//  Timing:
//   - Prescaler counts 0..TICK_DIV-1; the tick counter increments on wrap and saturates at 1023.
//   - Both prescaler and tick counter restart to 0 on every accepted colour change.
//  FSM:
//   - IDLE: wait for a legal colour; enter TRACK with the phase marked partial.
//   - TRACK: on an accepted change:
//     - Pulse phase_done; load phase_ticks with the tick counter value.
//     - If the ended phase is not partial and ticks < NOMINAL-TOL: set fault_time.
//     - If the new colour is not the expected successor: set fault_seq.
//     - If RED->GREEN and in order: increment cycle_count.
//     - The new phase is not partial (a real edge started it).
//   - Late detection: in TRACK, when ticks reaches NOMINAL+TOL+1, set fault_time immediately.
//     - Flagged once per phase; not re-checked at phase end.
//   - ILLEGAL accepted from any state:
//     - Set fault_illegal; colour=3, colour_valid=0; go to IDLE.
//     - Pulse phase_done only if leaving TRACK.
//  Sticky flags:
//   - clear_faults zeroes all three flags.
//   - A set event in the same cycle wins (flag reads 1).
//  Simultaneous faults: seq and time may both set on one transition.
//  Reset mid-phase: everything returns to reset values; the next phase is partial.
// STRUCTURE
//  Package tl_pkg:
//   - Colour codes GREEN/YELLOW/RED/NONE (2-bit).
//   - RGB patterns RGB_GREEN=3'b010, RGB_YELLOW=3'b110, RGB_RED=3'b100.
//   - FSM state typedef {IDLE, TRACK}.
//  Sub-module tl_rgb_filter: 2-FF sync + STABLE_CYCLES filter; outputs accepted pattern + change strobe.
//  Top holds decode, prescaler, tick counter, FSM, fault logic.
// TESTING (TICK_DIV=10, STABLE_CYCLES=4)
//  1. rst; 010 x1010 cyc, 110 x510, 100 x1010, 010 ->
//     - phase_done pulses with phase_ticks 51, then 101.
//     - cycle_count=1; no faults.
//  2. During green, 110 held 1..3 cycles -> ignored: no phase_done, colour stays 0.
//  3. Full green, then 100 (skip yellow) -> fault_seq=1, fault_time=0; tracking continues in RED.
//  4. Hold 110 indefinitely -> fault_time rises when ticks=54; exactly one rise; phase_ticks untouched.
//  5. 000 stable 4 cycles in TRACK ->
//     - fault_illegal=1, colour=3, colour_valid=0.
//     - Next legal colour is partial: no fault_time when it ends.
//  6. Two checks:
//     - clear_faults in the same cycle as a fault event -> flag stays 1.
//     - rst mid-yellow -> all outputs return to reset values.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared types and decode helpers for the traffic light lamp-bus monitor.
package tl_pkg;

  // Colour codes presented on the colour output
  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    RED    = 2'd2,
    NONE   = 2'd3
  } colour_t;

  // Legal lamp patterns, bit order {R,G,B}
  localparam logic [2:0] RGB_GREEN  = 3'b010;
  localparam logic [2:0] RGB_YELLOW = 3'b110;
  localparam logic [2:0] RGB_RED    = 3'b100;

  // Monitor state
  typedef enum logic {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam int         TICK_W   = 10;
  localparam logic [9:0] TICK_MAX = 10'd1023;

  // Map a lamp pattern to a colour; anything undefined becomes NONE
  function automatic colour_t decode_rgb(input logic [2:0] rgb);
    colour_t c;
    case (rgb)
      RGB_GREEN:  c = GREEN;
      RGB_YELLOW: c = YELLOW;
      RGB_RED:    c = RED;
      default:    c = NONE;
    endcase
    return c;
  endfunction

  // Colour that must follow c in a correct sequence
  function automatic colour_t next_colour(input colour_t c);
    colour_t n;
    case (c)
      GREEN:   n = YELLOW;
      YELLOW:  n = RED;
      RED:     n = GREEN;
      default: n = NONE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tl_rgb_filter.sv
// Two-flop synchroniser plus stability filter for the asynchronous lamp bus.
// A pattern is accepted once the synchronised bus has shown it for
// STABLE_CYCLES consecutive samples; change pulses in the cycle where an
// accepted pattern differs from the previously accepted one.
module tl_rgb_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] rgb_async,
  output logic [2:0] pattern,
  output logic       change
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [2:0]       sync1_q, sync2_q;
  logic [2:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       acc_q, acc_d;
  logic             accept_s;
  logic             change_s;

  // Count consecutive equal samples and detect acceptance of a new pattern
  always_comb begin
    cand_d   = sync2_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    change_s = 1'b0;
    if (sync2_q == cand_q) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = CNT_ONE;
    end
    accept_s = (cnt_d == CNT_MAX);
    if (accept_s && (sync2_q != acc_q)) begin
      acc_d    = sync2_q;
      change_s = 1'b1;
    end else begin
      acc_d    = acc_q;
      change_s = 1'b0;
    end
  end

  // Synchroniser and filter state; accepted pattern resets to all-off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      cand_q  <= 3'b000;
      cnt_q   <= '0;
      acc_q   <= 3'b000;
    end else begin
      sync1_q <= rgb_async;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end

  // The newly accepted pattern is the current synchronised sample
  assign pattern = sync2_q;
  assign change  = change_s;

endmodule

// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the traffic light lamp bus: decodes the filtered
// colour, measures each phase in ticks and raises sticky sequence, timing and
// illegal-pattern faults.
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int TICK_DIV      = 1_000_000,
  parameter int STABLE_CYCLES = 4,
  parameter int GREEN_TICKS   = 101,
  parameter int YELLOW_TICKS  = 51,
  parameter int RED_TICKS     = 101,
  parameter int TOL_TICKS     = 2
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic [2:0]  RGB_in,
  input  logic        clear_faults,
  output logic [1:0]  colour,
  output logic        colour_valid,
  output logic        phase_done,
  output logic [9:0]  phase_ticks,
  output logic        fault_seq,
  output logic        fault_time,
  output logic        fault_illegal,
  output logic [15:0] cycle_count
);

  localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);

  // Shortest acceptable dwell and first dwell that counts as late
  localparam logic [9:0] G_MIN  = 10'(GREEN_TICKS - TOL_TICKS);
  localparam logic [9:0] Y_MIN  = 10'(YELLOW_TICKS - TOL_TICKS);
  localparam logic [9:0] R_MIN  = 10'(RED_TICKS - TOL_TICKS);
  localparam logic [9:0] G_LATE = 10'(GREEN_TICKS + TOL_TICKS + 1);
  localparam logic [9:0] Y_LATE = 10'(YELLOW_TICKS + TOL_TICKS + 1);
  localparam logic [9:0] R_LATE = 10'(RED_TICKS + TOL_TICKS + 1);

  logic [2:0]         pattern_s;
  logic               change_s;
  colour_t            new_colour_s;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [9:0]         ticks_q, ticks_d;
  logic [9:0]         ticks_inc_s;
  logic               wrap_s;
  logic [9:0]         min_s, late_s;

  state_t             state_q, state_d;
  colour_t            colour_q, colour_d;
  logic               valid_q, valid_d;
  logic               partial_q, partial_d;
  logic               late_q, late_d;
  logic               phase_done_q, phase_done_d;
  logic [9:0]         phase_ticks_q, phase_ticks_d;
  logic               fault_seq_q, fault_seq_d;
  logic               fault_time_q, fault_time_d;
  logic               fault_illegal_q, fault_illegal_d;
  logic [15:0]        cycle_count_q, cycle_count_d;
  logic               set_seq_s, set_time_s, set_illegal_s;

  tl_rgb_filter #(
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk       (clk_100MHz),
    .rst       (rst),
    .rgb_async (RGB_in),
    .pattern   (pattern_s),
    .change    (change_s)
  );

  assign new_colour_s = decode_rgb(pattern_s);

  // Prescaler and saturating tick counter; ticks_inc_s includes this cycle's wrap
  always_comb begin
    wrap_s = (presc_q == PRESC_LAST);
    if (wrap_s && (ticks_q != TICK_MAX)) begin
      ticks_inc_s = ticks_q + 10'd1;
    end else begin
      ticks_inc_s = ticks_q;
    end
    if (change_s) begin
      presc_d = '0;
      ticks_d = 10'd0;
    end else if (wrap_s) begin
      presc_d = '0;
      ticks_d = ticks_inc_s;
    end else begin
      presc_d = presc_q + PRESC_ONE;
      ticks_d = ticks_inc_s;
    end
  end

  // Dwell limits for the colour currently being tracked
  always_comb begin
    case (colour_q)
      GREEN:   begin min_s = G_MIN;      late_s = G_LATE;   end
      YELLOW:  begin min_s = Y_MIN;      late_s = Y_LATE;   end
      RED:     begin min_s = R_MIN;      late_s = R_LATE;   end
      default: begin min_s = 10'd0;      late_s = TICK_MAX; end
    endcase
  end

  // Phase tracking, ordering/timing checks and sticky fault flags
  always_comb begin
    state_d       = state_q;
    colour_d      = colour_q;
    valid_d       = valid_q;
    partial_d     = partial_q;
    late_d        = late_q;
    phase_done_d  = 1'b0;
    phase_ticks_d = phase_ticks_q;
    cycle_count_d = cycle_count_q;
    set_seq_s     = 1'b0;
    set_time_s    = 1'b0;
    set_illegal_s = 1'b0;

    if (change_s && (new_colour_s == NONE)) begin
      set_illegal_s = 1'b1;
      colour_d      = NONE;
      valid_d       = 1'b0;
      state_d       = IDLE;
      if (state_q == TRACK) begin
        phase_done_d  = 1'b1;
        phase_ticks_d = ticks_inc_s;
      end else begin
        phase_done_d  = 1'b0;
      end
    end else if (change_s && (state_q == IDLE)) begin
      // First legal colour after reset or an illegal pattern: length unknown
      state_d   = TRACK;
      colour_d  = new_colour_s;
      valid_d   = 1'b1;
      partial_d = 1'b1;
      late_d    = 1'b0;
    end else if (change_s) begin
      phase_done_d  = 1'b1;
      phase_ticks_d = ticks_inc_s;
      if (!partial_q && (ticks_inc_s < min_s)) begin
        set_time_s = 1'b1;
      end else begin
        set_time_s = 1'b0;
      end
      if (new_colour_s != next_colour(colour_q)) begin
        set_seq_s = 1'b1;
      end else if (colour_q == RED) begin
        cycle_count_d = cycle_count_q + 16'd1;
      end else begin
        set_seq_s = 1'b0;
      end
      colour_d  = new_colour_s;
      partial_d = 1'b0;
      late_d    = 1'b0;
    end else if ((state_q == TRACK) && !late_q && (ticks_inc_s >= late_s)) begin
      // Overrun is flagged as soon as it happens, once per phase
      set_time_s = 1'b1;
      late_d     = 1'b1;
    end else begin
      late_d = late_q;
    end

    fault_seq_d     = (fault_seq_q     & ~clear_faults) | set_seq_s;
    fault_time_d    = (fault_time_q    & ~clear_faults) | set_time_s;
    fault_illegal_d = (fault_illegal_q & ~clear_faults) | set_illegal_s;
  end

  // All monitor state and registered outputs
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      presc_q         <= '0;
      ticks_q         <= 10'd0;
      state_q         <= IDLE;
      colour_q        <= NONE;
      valid_q         <= 1'b0;
      partial_q       <= 1'b1;
      late_q          <= 1'b0;
      phase_done_q    <= 1'b0;
      phase_ticks_q   <= 10'd0;
      fault_seq_q     <= 1'b0;
      fault_time_q    <= 1'b0;
      fault_illegal_q <= 1'b0;
      cycle_count_q   <= 16'd0;
    end else begin
      presc_q         <= presc_d;
      ticks_q         <= ticks_d;
      state_q         <= state_d;
      colour_q        <= colour_d;
      valid_q         <= valid_d;
      partial_q       <= partial_d;
      late_q          <= late_d;
      phase_done_q    <= phase_done_d;
      phase_ticks_q   <= phase_ticks_d;
      fault_seq_q     <= fault_seq_d;
      fault_time_q    <= fault_time_d;
      fault_illegal_q <= fault_illegal_d;
      cycle_count_q   <= cycle_count_d;
    end
  end

  assign colour        = colour_q;
  assign colour_valid  = valid_q;
  assign phase_done    = phase_done_q;
  assign phase_ticks   = phase_ticks_q;
  assign fault_seq     = fault_seq_q;
  assign fault_time    = fault_time_q;
  assign fault_illegal = fault_illegal_q;
  assign cycle_count   = cycle_count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with TICK_DIV=10, STABLE_CYCLES=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_traffic_light_monitor;

  logic        clk_100MHz = 1'b0;
  logic        rst;
  logic [2:0]  RGB_in;
  logic        clear_faults;
  logic [1:0]  colour;
  logic        colour_valid;
  logic        phase_done;
  logic [9:0]  phase_ticks;
  logic        fault_seq;
  logic        fault_time;
  logic        fault_illegal;
  logic [15:0] cycle_count;

  int n_total = 0;
  int n_pass  = 0;
  int pd_count = 0;
  int pd_last  = 0;
  int ft_rises = 0;
  logic ft_prev = 1'b0;

  traffic_light_monitor #(
    .TICK_DIV      (10),
    .STABLE_CYCLES (4),
    .GREEN_TICKS   (101),
    .YELLOW_TICKS  (51),
    .RED_TICKS     (101),
    .TOL_TICKS     (2)
  ) dut (
    .clk_100MHz    (clk_100MHz),
    .rst           (rst),
    .RGB_in        (RGB_in),
    .clear_faults  (clear_faults),
    .colour        (colour),
    .colour_valid  (colour_valid),
    .phase_done    (phase_done),
    .phase_ticks   (phase_ticks),
    .fault_seq     (fault_seq),
    .fault_time    (fault_time),
    .fault_illegal (fault_illegal),
    .cycle_count   (cycle_count)
  );

  // 100 MHz clock
  always #5 clk_100MHz = ~clk_100MHz;

  // Record phase_done pulses and rising edges of fault_time
  always @(negedge clk_100MHz) begin
    if (phase_done === 1'b1) begin
      pd_count <= pd_count + 1;
      pd_last  <= 32'(phase_ticks);
    end
    ft_prev <= fault_time;
    if ((fault_time === 1'b1) && (ft_prev === 1'b0)) begin
      ft_rises <= ft_rises + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      n_pass = n_pass + 1;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic hold(input logic [2:0] p, input int n);
    RGB_in = p;
    wait_cyc(n);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_colour"},  32'(colour),        32'd3);
    check_eq({tag, "_valid"},   32'(colour_valid),  32'd0);
    check_eq({tag, "_pdone"},   32'(phase_done),    32'd0);
    check_eq({tag, "_pticks"},  32'(phase_ticks),   32'd0);
    check_eq({tag, "_fseq"},    32'(fault_seq),     32'd0);
    check_eq({tag, "_ftime"},   32'(fault_time),    32'd0);
    check_eq({tag, "_fill"},    32'(fault_illegal), 32'd0);
    check_eq({tag, "_cycles"},  32'(cycle_count),   32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    RGB_in       = 3'b000;
    clear_faults = 1'b0;
    wait_cyc(3);
    check_reset_values("reset");
    rst = 1'b0;
    wait_cyc(3);

    // 1: one full legal cycle
    hold(3'b010, 1010);
    check_eq("t1_green_col", 32'(colour), 32'd0);
    check_eq("t1_green_valid", 32'(colour_valid), 32'd1);
    check_eq("t1_no_pd_from_idle", 32'(pd_count), 32'd0);
    hold(3'b110, 510);
    check_eq("t1_yellow_col", 32'(colour), 32'd1);
    check_eq("t1_pd_green_cnt", 32'(pd_count), 32'd1);
    check_eq("t1_pd_green_ticks", 32'(pd_last), 32'd101);
    hold(3'b100, 1010);
    check_eq("t1_red_col", 32'(colour), 32'd2);
    check_eq("t1_pd_yellow_ticks", 32'(pd_last), 32'd51);
    RGB_in = 3'b010;
    wait_cyc(5);
    check_eq("t1_latency_before", 32'(colour), 32'd2);
    wait_cyc(1);
    check_eq("t1_latency_at", 32'(colour), 32'd0);
    check_eq("t1_pd_red", 32'(phase_done), 32'd1);
    check_eq("t1_red_ticks", 32'(phase_ticks), 32'd101);
    check_eq("t1_cycles", 32'(cycle_count), 32'd1);
    check_eq("t1_fseq", 32'(fault_seq), 32'd0);
    check_eq("t1_ftime", 32'(fault_time), 32'd0);
    check_eq("t1_fill", 32'(fault_illegal), 32'd0);

    // 2: short yellow glitches during green are filtered out
    for (int w = 1; w <= 3; w++) begin
      hold(3'b110, w);
      hold(3'b010, 10);
    end
    check_eq("t2_pd_count", 32'(pd_count), 32'd3);
    check_eq("t2_colour", 32'(colour), 32'd0);

    // 3: full green then skip yellow
    hold(3'b010, 968);
    RGB_in = 3'b100;
    wait_cyc(6);
    check_eq("t3_colour", 32'(colour), 32'd2);
    check_eq("t3_valid", 32'(colour_valid), 32'd1);
    check_eq("t3_pd", 32'(phase_done), 32'd1);
    check_eq("t3_green_ticks", 32'(phase_ticks), 32'd101);
    check_eq("t3_fseq", 32'(fault_seq), 32'd1);
    check_eq("t3_ftime", 32'(fault_time), 32'd0);
    check_eq("t3_cycles", 32'(cycle_count), 32'd1);
    clear_faults = 1'b1;
    wait_cyc(1);
    clear_faults = 1'b0;
    check_eq("t3_clear_fseq", 32'(fault_seq), 32'd0);

    // 4: finish red, full green, then yellow held far too long
    hold(3'b100, 1003);
    hold(3'b010, 1010);
    check_eq("t4_cycles", 32'(cycle_count), 32'd2);
    check_eq("t4_red_ticks", 32'(pd_last), 32'd101);
    check_eq("t4_fseq_ok", 32'(fault_seq), 32'd0);
    RGB_in = 3'b110;
    wait_cyc(545);
    check_eq("t4_ftime_at53", 32'(fault_time), 32'd0);
    check_eq("t4_yellow_col", 32'(colour), 32'd1);
    wait_cyc(1);
    check_eq("t4_ftime_at54", 32'(fault_time), 32'd1);
    wait_cyc(300);
    check_eq("t4_pticks_kept", 32'(phase_ticks), 32'd101);
    check_eq("t4_one_rise", 32'(ft_rises), 32'd1);
    clear_faults = 1'b1;
    wait_cyc(1);
    clear_faults = 1'b0;
    wait_cyc(100);
    check_eq("t4_no_reflag", 32'(fault_time), 32'd0);
    wait_cyc(9353);
    RGB_in = 3'b100;
    wait_cyc(6);
    check_eq("t4_sat_pd", 32'(phase_done), 32'd1);
    check_eq("t4_sat_ticks", 32'(phase_ticks), 32'd1023);
    check_eq("t4_end_ftime", 32'(fault_time), 32'd0);
    check_eq("t4_end_fseq", 32'(fault_seq), 32'd0);
    check_eq("t4_rises_final", 32'(ft_rises), 32'd1);

    // 5: illegal pattern in TRACK, then a partial phase
    wait_cyc(1004);
    RGB_in = 3'b000;
    wait_cyc(6);
    check_eq("t5_fill", 32'(fault_illegal), 32'd1);
    check_eq("t5_colour", 32'(colour), 32'd3);
    check_eq("t5_valid", 32'(colour_valid), 32'd0);
    check_eq("t5_pd", 32'(phase_done), 32'd1);
    check_eq("t5_red_ticks", 32'(phase_ticks), 32'd101);
    wait_cyc(14);
    hold(3'b010, 300);
    check_eq("t5_green_col", 32'(colour), 32'd0);
    RGB_in = 3'b110;
    wait_cyc(6);
    check_eq("t5_partial_pd", 32'(phase_done), 32'd1);
    check_eq("t5_partial_ticks", 32'(phase_ticks), 32'd30);
    check_eq("t5_partial_ftime", 32'(fault_time), 32'd0);
    check_eq("t5_partial_fseq", 32'(fault_seq), 32'd0);
    check_eq("t5_fill_sticky", 32'(fault_illegal), 32'd1);

    // 6a: short yellow to green with clear_faults on the same edge
    wait_cyc(94);
    RGB_in = 3'b010;
    wait_cyc(5);
    clear_faults = 1'b1;
    wait_cyc(1);
    clear_faults = 1'b0;
    check_eq("t6_pd", 32'(phase_done), 32'd1);
    check_eq("t6_ticks", 32'(phase_ticks), 32'd10);
    check_eq("t6_fseq_wins", 32'(fault_seq), 32'd1);
    check_eq("t6_ftime_wins", 32'(fault_time), 32'd1);
    check_eq("t6_fill_cleared", 32'(fault_illegal), 32'd0);
    check_eq("t6_colour", 32'(colour), 32'd0);
    check_eq("t6_cycles", 32'(cycle_count), 32'd2);

    // 6b: asynchronous reset mid-yellow
    hold(3'b110, 50);
    check_eq("t6_yellow_col", 32'(colour), 32'd1);
    @(posedge clk_100MHz);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("t6_async");
    wait_cyc(1);
    check_reset_values("t6_held");
    rst = 1'b0;
    wait_cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
